// File: rtl/pkc_pkg.sv
// Shared parameters, FSM state encoding and helpers for the McEliece-style PKC datapath.
package pkc_pkg;
  localparam int unsigned Q        = 3;
  localparam int unsigned T        = 1;
  localparam int unsigned NMSG     = Q * Q;
  localparam int unsigned NCHK     = 2 * T * Q;
  localparam int unsigned K        = NMSG + NCHK;
  localparam int unsigned MAX_ITER = 2 * T + 1;
  localparam int unsigned CNT_W    = $clog2(K + 1);
  localparam int unsigned ITER_W   = $clog2(MAX_ITER + 1);

  typedef enum logic [4:0] {
    IDLE, LD_G, GAP_S, LD_S, GAP_P, LD_P, KEYGEN, KEY_RDY, LD_HR, GAP_HC,
    LD_HC, GAP_SI, LD_SI, GAP_PI, LD_PI, DEC_PERM, DEC_SYN, DEC_UNSCR, DONE
  } pkc_state_e;

  function automatic int unsigned popcnt(input logic [NCHK-1:0] v);
    int unsigned c;
    c = 0;
    for (int unsigned i = 0; i < NCHK; i++)
      if (v[i]) c++;
    return c;
  endfunction
endpackage

// File: rtl/pkc_syndrome_decoder.sv
// Iterative bit-flipping syndrome decoder; vectors use MSB = index 0.
module pkc_syndrome_decoder
  import pkc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  logic [K-1:0]    i_hrow [NCHK],
  input  logic [NCHK-1:0] i_hcol [K],
  input  logic [K-1:0]    i_c,
  output logic [K-1:0]    o_c,
  output logic            o_done
);
  logic [K-1:0]      r_c;
  logic [ITER_W-1:0] r_iter;
  logic              r_busy;
  logic              r_done;
  logic [NCHK-1:0]   w_syn;
  logic [K-1:0]      w_flip;

  always_comb begin
    w_syn  = '0;
    w_flip = '0;
    for (int unsigned r = 0; r < NCHK; r++)
      w_syn[NCHK-1-r] = ^(i_hrow[r] & r_c);
    // Flip a bit only when every check it participates in is unsatisfied.
    for (int unsigned j = 0; j < K; j++)
      w_flip[K-1-j] = (popcnt(w_syn & i_hcol[j]) == popcnt(i_hcol[j]));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c    <= '0;
      r_iter <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_c    <= i_c;
      r_iter <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      if (w_syn == '0 || r_iter == ITER_W'(MAX_ITER)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_c    <= r_c ^ w_flip;
        r_iter <= r_iter + ITER_W'(1);
      end
    end
  end

  assign o_c    = r_c;
  assign o_done = r_done;
endmodule

// File: rtl/mceliece_pkc_top.sv
// McEliece-style key load, public-key generation, encryption and decryption.
// Optional debug outputs (ciphertext, key_ready) enabled by PKC_DEBUG_PORTS_EN.
module mceliece_pkc_top
  import pkc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            generator_ready,
  input  logic [K-1:0]    generator,
  input  logic            S_ready,
  input  logic [NMSG-1:0] S,
  input  logic            P_ready,
  input  logic [K-1:0]    P,
  input  logic [NMSG-1:0] message,
  input  logic [K-1:0]    error,
  input  logic            parity_ready,
  input  logic [K-1:0]    parity_check_row,
  input  logic [NCHK-1:0] parity_check_col,
  input  logic            S_inv_ready,
  input  logic [NMSG-1:0] S_inv,
  input  logic            P_inv_ready,
  input  logic [K-1:0]    P_inv,
  output logic [NMSG-1:0] dec_message,
  output logic            dec_msg_ready
`ifdef PKC_DEBUG_PORTS_EN
  ,
  output logic [K-1:0]    ciphertext,
  output logic            key_ready
`endif
);
  pkc_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [K-1:0]    r_g    [NMSG];
  logic [NMSG-1:0] r_s    [NMSG];
  logic [K-1:0]    r_p    [K];
  logic [K-1:0]    r_gpub [NMSG];
  logic [K-1:0]    r_hr   [NCHK];
  logic [NCHK-1:0] r_hc   [K];
  logic [NMSG-1:0] r_si   [NMSG];
  logic [K-1:0]    r_pi   [K];
  logic [K-1:0]    r_c;
  logic [K-1:0]    r_cp;
  logic            r_dec_start;
  logic [NMSG-1:0] r_dec_message;
  logic            r_dec_msg_ready;

  logic            w_ready, w_last;
  int unsigned     w_lim;
  logic [NMSG-1:0] w_srow, w_msg;
  logic [K-1:0]    w_sg, w_gp, w_c, w_cp, w_dec_c;
  logic            w_dec_done;

  always_comb begin
    w_ready = 1'b0;
    w_lim   = NMSG;
    case (r_state)
      LD_G:    w_ready = generator_ready;
      LD_S:    w_ready = S_ready;
      LD_P:    begin w_ready = P_ready;      w_lim = K;    end
      KEYGEN:  w_ready = 1'b1;
      LD_HR:   begin w_ready = parity_ready; w_lim = NCHK; end
      LD_HC:   begin w_ready = parity_ready; w_lim = K;    end
      LD_SI:   w_ready = S_inv_ready;
      LD_PI:   begin w_ready = P_inv_ready;  w_lim = K;    end
      default: ;
    endcase
    w_last = (r_cnt == CNT_W'(w_lim - 1));
  end

  always_comb begin
    w_srow = '0;
    w_sg   = '0;
    w_gp   = '0;
    w_c    = '0;
    w_cp   = '0;
    w_msg  = '0;
    for (int unsigned i = 0; i < NMSG; i++)
      if (r_cnt == CNT_W'(i)) w_srow = r_s[i];
    for (int unsigned k = 0; k < NMSG; k++)
      if (w_srow[NMSG-1-k]) w_sg ^= r_g[k];
    for (int unsigned j = 0; j < K; j++)
      w_gp[K-1-j] = ^(w_sg & r_p[j]);
    for (int unsigned i = 0; i < NMSG; i++)
      if (message[NMSG-1-i]) w_c ^= r_gpub[i];
    w_c = w_c ^ error;
    for (int unsigned j = 0; j < K; j++)
      w_cp[K-1-j] = ^(r_c & r_pi[j]);
    for (int unsigned i = 0; i < NMSG; i++)
      if (r_cp[K-1-i]) w_msg ^= r_si[i];
  end

  pkc_syndrome_decoder u_dec (
    .clk     (clk),
    .reset   (reset),
    .i_start (r_dec_start),
    .i_hrow  (r_hr),
    .i_hcol  (r_hc),
    .i_c     (r_cp),
    .o_c     (w_dec_c),
    .o_done  (w_dec_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_c             <= '0;
      r_cp            <= '0;
      r_dec_start     <= 1'b0;
      r_dec_message   <= '0;
      r_dec_msg_ready <= 1'b0;
      for (int unsigned i = 0; i < NMSG; i++) begin
        r_g[i] <= '0; r_s[i] <= '0; r_gpub[i] <= '0; r_si[i] <= '0;
      end
      for (int unsigned i = 0; i < K; i++) begin
        r_p[i] <= '0; r_hc[i] <= '0; r_pi[i] <= '0;
      end
      for (int unsigned i = 0; i < NCHK; i++) r_hr[i] <= '0;
    end else begin
      // One shared word/row counter serves every load state and KEYGEN.
      if (w_ready) r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      case (r_state)
        IDLE:    if (start) r_state <= LD_G;
        LD_G:    if (generator_ready) begin
                   for (int unsigned i = 0; i < NMSG; i++)
                     if (r_cnt == CNT_W'(i)) r_g[i] <= generator;
                   if (w_last) r_state <= GAP_S;
                 end
        GAP_S:   r_state <= LD_S;
        LD_S:    if (S_ready) begin
                   for (int unsigned i = 0; i < NMSG; i++)
                     if (r_cnt == CNT_W'(i)) r_s[i] <= S;
                   if (w_last) r_state <= GAP_P;
                 end
        GAP_P:   r_state <= LD_P;
        LD_P:    if (P_ready) begin
                   for (int unsigned i = 0; i < K; i++)
                     if (r_cnt == CNT_W'(i)) r_p[i] <= P;
                   if (w_last) r_state <= KEYGEN;
                 end
        KEYGEN:  begin
                   for (int unsigned i = 0; i < NMSG; i++)
                     if (r_cnt == CNT_W'(i)) r_gpub[i] <= w_gp;
                   if (w_last) r_state <= KEY_RDY;
                 end
        KEY_RDY: if (parity_ready) begin
                   r_c     <= w_c;
                   r_state <= LD_HR;
                 end
        LD_HR:   if (parity_ready) begin
                   for (int unsigned i = 0; i < NCHK; i++)
                     if (r_cnt == CNT_W'(i)) r_hr[i] <= parity_check_row;
                   if (w_last) r_state <= GAP_HC;
                 end
        GAP_HC:  r_state <= LD_HC;
        LD_HC:   if (parity_ready) begin
                   for (int unsigned i = 0; i < K; i++)
                     if (r_cnt == CNT_W'(i)) r_hc[i] <= parity_check_col;
                   if (w_last) r_state <= GAP_SI;
                 end
        GAP_SI:  r_state <= LD_SI;
        LD_SI:   if (S_inv_ready) begin
                   for (int unsigned i = 0; i < NMSG; i++)
                     if (r_cnt == CNT_W'(i)) r_si[i] <= S_inv;
                   if (w_last) r_state <= GAP_PI;
                 end
        GAP_PI:  r_state <= LD_PI;
        LD_PI:   if (P_inv_ready) begin
                   for (int unsigned i = 0; i < K; i++)
                     if (r_cnt == CNT_W'(i)) r_pi[i] <= P_inv;
                   if (w_last) r_state <= DEC_PERM;
                 end
        DEC_PERM: begin
                   r_cp        <= w_cp;
                   r_dec_start <= 1'b1;
                   r_state     <= DEC_SYN;
                 end
        DEC_SYN: begin
                   r_dec_start <= 1'b0;
                   if (w_dec_done) begin
                     r_cp    <= w_dec_c;
                     r_state <= DEC_UNSCR;
                   end
                 end
        DEC_UNSCR: begin
                   r_dec_message   <= w_msg;
                   r_dec_msg_ready <= 1'b1;
                   r_state         <= DONE;
                 end
        DONE:    ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dec_message   = r_dec_message;
  assign dec_msg_ready = r_dec_msg_ready;
`ifdef PKC_DEBUG_PORTS_EN
  assign ciphertext = r_c;
  assign key_ready  = (r_state >= KEY_RDY);
`endif
endmodule

// File: tb/tb_mceliece_pkc_top.sv
// Directed bench: 3x3 product-code keys, scoreboard of expected plaintexts.
module tb_mceliece_pkc_top;
  import pkc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start;
  logic            generator_ready, S_ready, P_ready, parity_ready, S_inv_ready, P_inv_ready;
  logic [K-1:0]    generator, P, error, parity_check_row, P_inv;
  logic [NMSG-1:0] S, message, S_inv, dec_message;
  logic [NCHK-1:0] parity_check_col;
  logic            dec_msg_ready;
`ifdef PKC_DEBUG_PORTS_EN
  logic [K-1:0]    ciphertext;
  logic            key_ready;
`endif

  mceliece_pkc_top dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .generator_ready  (generator_ready),
    .generator        (generator),
    .S_ready          (S_ready),
    .S                (S),
    .P_ready          (P_ready),
    .P                (P),
    .message          (message),
    .error            (error),
    .parity_ready     (parity_ready),
    .parity_check_row (parity_check_row),
    .parity_check_col (parity_check_col),
    .S_inv_ready      (S_inv_ready),
    .S_inv            (S_inv),
    .P_inv_ready      (P_inv_ready),
    .P_inv            (P_inv),
    .dec_message      (dec_message),
    .dec_msg_ready    (dec_msg_ready)
`ifdef PKC_DEBUG_PORTS_EN
    ,
    .ciphertext       (ciphertext),
    .key_ready        (key_ready)
`endif
  );

  int unsigned     total = 0;
  int unsigned     bad   = 0;
  logic [NMSG-1:0] exp_q [$];

  logic [K-1:0]    g   [NMSG];
  logic [NMSG-1:0] s   [NMSG];
  logic [NMSG-1:0] si  [NMSG];
  logic [K-1:0]    pc  [K];
  logic [K-1:0]    pic [K];
  logic [K-1:0]    hr  [NCHK];
  logic [NCHK-1:0] hc  [K];

  function automatic logic [K-1:0] kb(input int unsigned i);
    logic [K-1:0] v;
    v = '0;
    v[K-1-i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NMSG-1:0] nb(input int unsigned i);
    logic [NMSG-1:0] v;
    v = '0;
    v[NMSG-1-i] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic build_keys;
    int unsigned perm [K];
    int unsigned pinv [K];
    for (int unsigned i = 0; i < NMSG; i++) begin
      g[i]  = kb(i) | kb(NMSG + i / Q) | kb(NMSG + Q + i % Q);
      s[i]  = (i < NMSG - 1) ? (nb(i) | nb(i + 1)) : nb(i);
      si[i] = '0;
      for (int unsigned k = i; k < NMSG; k++) si[i] |= nb(k);
    end
    for (int unsigned j = 0; j < K; j++) begin
      perm[j] = (7 * j + 3) % K;
      pinv[perm[j]] = j;
    end
    for (int unsigned j = 0; j < K; j++) begin
      pc[j]  = kb(perm[j]);
      pic[j] = kb(pinv[j]);
    end
    for (int unsigned r = 0; r < Q; r++) begin
      hr[r]     = kb(Q * r) | kb(Q * r + 1) | kb(Q * r + 2) | kb(NMSG + r);
      hr[Q + r] = kb(r) | kb(r + Q) | kb(r + 2 * Q) | kb(NMSG + Q + r);
    end
    for (int unsigned j = 0; j < K; j++) begin
      hc[j] = '0;
      for (int unsigned r = 0; r < NCHK; r++) hc[j][NCHK-1-r] = hr[r][K-1-j];
    end
  endtask

  task automatic set_word(input int unsigned which, input int unsigned i, input logic rdy);
    generator_ready = 1'b0; S_ready = 1'b0; P_ready = 1'b0;
    parity_ready = 1'b0; S_inv_ready = 1'b0; P_inv_ready = 1'b0;
    case (which)
      0: begin generator_ready = rdy; generator = g[i]; end
      1: begin S_ready = rdy; S = s[i]; end
      2: begin P_ready = rdy; P = pc[i]; end
      3: begin parity_ready = rdy; parity_check_row = hr[i]; end
      4: begin parity_ready = rdy; parity_check_col = hc[i]; end
      5: begin S_inv_ready = rdy; S_inv = si[i]; end
      default: begin P_inv_ready = rdy; P_inv = pic[i]; end
    endcase
  endtask

  task automatic load(input int unsigned which, input int unsigned cnt, input bit drop);
    for (int unsigned i = 0; i < cnt; i++) begin
      if (drop && i == 4) begin
        set_word(which, i, 1'b0);
        repeat (3) tick;
      end
      set_word(which, i, 1'b1);
      tick;
    end
    set_word(which, 0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; message = '0; error = '0;
    set_word(0, 0, 1'b0);
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic load_pub(input bit drop);
    start = 1'b1; tick; start = 1'b0;
    load(0, NMSG, drop); tick;
    load(1, NMSG, 1'b0); tick;
    load(2, K, 1'b0);
  endtask

  task automatic run(input string tag, input logic [NMSG-1:0] msg, input logic [K-1:0] err,
                     input bit drop, input bit exact);
    int unsigned cyc;
    logic [NMSG-1:0] e;
    load_pub(drop);
    repeat (NMSG + 2) tick;
    message = msg; error = err;
    if (exact) exp_q.push_back(msg);
    parity_ready = 1'b1; tick; parity_ready = 1'b0;
    load(3, NCHK, 1'b0); tick;
    load(4, K, 1'b0); tick;
    load(5, NMSG, 1'b0); tick;
    chk({tag, "_rdy_early"}, {31'b0, dec_msg_ready}, 32'd0);
    load(6, K, 1'b0);
    cyc = 0;
    while (dec_msg_ready !== 1'b1 && cyc < 100) begin tick; cyc++; end
    chk({tag, "_rdy"}, {31'b0, dec_msg_ready}, 32'd1);
    if (exact) begin
      e = exp_q.pop_front();
      chk({tag, "_msg"}, {23'b0, dec_message}, {23'b0, e});
    end
  endtask

  initial begin
    build_keys();
    do_reset();
    chk("reset_rdy", {31'b0, dec_msg_ready}, 32'd0);
    chk("reset_msg", {23'b0, dec_message}, 32'd0);

    run("err_msgbit", 9'b001100001, 15'b100000000000000, 1'b0, 1'b1);
    start = 1'b1; repeat (5) tick; start = 1'b0;
    chk("done_hold_rdy", {31'b0, dec_msg_ready}, 32'd1);
    chk("done_hold_msg", {23'b0, dec_message}, {23'b0, 9'b001100001});

    do_reset();
    run("no_err", 9'b101011010, '0, 1'b0, 1'b1);
    do_reset();
    run("err_chk", 9'b001100001, 15'b000000000000001, 1'b0, 1'b1);
    do_reset();
    run("g_stall", 9'b001100001, 15'b100000000000000, 1'b1, 1'b1);

    do_reset();
    load_pub(1'b0);
    repeat (4) tick;
    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_reset_rdy", {31'b0, dec_msg_ready}, 32'd0);
    chk("mid_reset_msg", {23'b0, dec_message}, 32'd0);
    run("after_reset", 9'b110010011, kb(6), 1'b0, 1'b1);

    for (int unsigned p = 0; p < K; p++) begin
      do_reset();
      run($sformatf("ones_e%0d", p), 9'h1FF, kb(p), 1'b0, 1'b1);
    end

    do_reset();
    run("weight2", 9'b010101010, kb(0) | kb(5), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
